updown_counter: RTL and testbench
=================================

UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 Parameter TICK_DIV, default 10_000_000, clk cycles per count step (10 Hz at 100 MHz); legal range 2 and up.
REQ-002 Parameter MAX_COUNT, default 9999, highest count value; legal range 1 to 16383.
REQ-003 clk  input  1  system clock; the only clock, all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_run_stop  input  1  single-cycle pulse from upstream debouncer; toggles run/stop.
REQ-006 btn_clear  input  1  single-cycle pulse; zeroes the count.
REQ-007 btn_mode  input  1  single-cycle pulse; toggles up/down direction.
REQ-008 count_data  output  14  current count, 0..MAX_COUNT, binary; drives the FND controller count input.
REQ-009 run_led  output  1  high while the FSM is in RUN.
REQ-010 mode_led  output  1  0 = up-count, 1 = down-count.

Function
REQ-011 The FSM SHALL have exactly three states: STOP, RUN and CLEAR.
REQ-012 STOP -> RUN on btn_run_stop; RUN -> STOP on btn_run_stop.
REQ-013 btn_clear in any state SHALL enter CLEAR on the next edge; CLEAR SHALL last exactly one cycle and then go to STOP unconditionally.
REQ-014 btn_clear and btn_run_stop in the same cycle: clear wins, run_stop is ignored.
REQ-015 Pulses arriving while in CLEAR SHALL be ignored, except btn_mode.
REQ-016 count_data SHALL be 0 in the cycle after CLEAR is entered; mode_led SHALL be unaffected by clear.
REQ-017 btn_mode SHALL toggle mode_led on the next edge in every state; the new direction applies from the next count step.
REQ-018 The tick divider SHALL count only in RUN and SHALL be held at 0 in STOP and CLEAR.
REQ-019 The first step after entering RUN SHALL occur exactly TICK_DIV cycles after the RUN entry edge; subsequent steps SHALL be every TICK_DIV cycles.
REQ-020 Tick: one-cycle pulse when the divider equals TICK_DIV-1; the divider then wraps to 0.
REQ-021 count_data SHALL change on the clock edge on which the tick is high (registered output, 1-cycle latency from the divider reaching TICK_DIV-1).
REQ-022 Up mode: count+1; MAX_COUNT wraps to 0.
REQ-023 Down mode: count-1; 0 wraps to MAX_COUNT.
REQ-024 Arithmetic SHALL be 14-bit unsigned; count_data SHALL never exceed MAX_COUNT.
REQ-025 Stopping in the same cycle as a tick: the step SHALL still be applied, then STOP is entered.
REQ-026 btn_mode coinciding with a tick: the step uses the old direction.

Reset
REQ-027 On reset: state = STOP, count_data = 0, divider = 0, run_led = 0, mode_led = 0 (up).
REQ-028 Reset SHALL override all button inputs in the same cycle, including during RUN and CLEAR.

Structure
REQ-029 State encodings (STOP, RUN, CLEAR) and the default TICK_DIV and MAX_COUNT values SHALL live in a shared package named counter_pkg.
REQ-030 The tick divider SHALL be one sub-module named tick_gen, with ports clk, reset, enable and o_tick.
REQ-031 The FSM and the count register SHALL reside in updown_counter.

Verification (TICK_DIV = 4, MAX_COUNT = 9999 on the bench)
REQ-032 Reset, then run_stop pulse, then wait 40 cycles -> count_data = 10 and run_led = 1; the first increment occurs exactly 4 cycles after RUN entry.
REQ-033 Preload count to 9998 in up mode, run for 2 ticks -> count goes 9999 then 0.
REQ-034 From 0, mode pulse then run for 1 tick -> count = 9999 and mode_led = 1.
REQ-035 During RUN at count 57, btn_clear and btn_run_stop in the same cycle -> count = 0 next cycle, FSM in STOP after one CLEAR cycle, run_led = 0.
REQ-036 Stop at count 5, idle 100 cycles, run again -> count stays 5 throughout STOP, then the next increment lands exactly 4 cycles after restart.
REQ-037 Assert reset mid-RUN at count 123 -> count_data = 0, run_led = 0 and mode_led = 0 on the next edge.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types, defaults and step arithmetic for the up/down counter
package counter_pkg;

  localparam int COUNT_W           = 14;
  localparam int DEFAULT_TICK_DIV  = 10_000_000;
  localparam int DEFAULT_MAX_COUNT = 9999;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Wraps in both directions; the >= guard keeps the result within max.
  function automatic logic [COUNT_W-1:0] next_count(
    input logic [COUNT_W-1:0] cur,
    input logic               down,
    input logic [COUNT_W-1:0] max
  );
    if (down) begin
      next_count = (cur == '0) ? max : cur - COUNT_W'(1);
    end else begin
      next_count = (cur >= max) ? '0 : cur + COUNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - enable-gated divider producing a one-cycle tick every TICK_DIV cycles
module tick_gen
  import counter_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic o_tick
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q;

  // Held at zero while disabled so a restart always yields a full period.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_q <= '0;
    end else if (div_q == LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign o_tick = enable && (div_q == LAST);

endmodule

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - run/stop/clear FSM with a wrapping up/down count register
module updown_counter
  import counter_pkg::*;
#(
  parameter int TICK_DIV  = DEFAULT_TICK_DIV,
  parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_run_stop,
  input  logic               btn_clear,
  input  logic               btn_mode,
  output logic [COUNT_W-1:0] count_data,
  output logic               run_led,
  output logic               mode_led
);

  localparam logic [COUNT_W-1:0] MAX_VAL = COUNT_W'(MAX_COUNT);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q;
  logic               mode_q;
  logic               tick;
  logic               enter_clear;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .enable(state_q == ST_RUN),
    .o_tick(tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // Clear has priority over run/stop; CLEAR itself ignores both buttons.
  always_comb begin
    state_d = state_q;
    run_led = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (btn_clear)         state_d = ST_CLEAR;
        else if (btn_run_stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        run_led = 1'b1;
        if (btn_clear)         state_d = ST_CLEAR;
        else if (btn_run_stop) state_d = ST_STOP;
      end
      ST_CLEAR: state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
  end

  assign enter_clear = btn_clear && (state_q != ST_CLEAR);

  // A tick on the stopping edge still steps, using the pre-toggle direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      if (btn_mode) mode_q <= ~mode_q;
      if (enter_clear) begin
        count_q <= '0;
      end else if (tick) begin
        count_q <= next_count(count_q, mode_q, MAX_VAL);
      end
    end
  end

  assign count_data = count_q;
  assign mode_led   = mode_q;

endmodule

// File: tb/tb_updown_counter.sv
// tb/tb_updown_counter.sv - directed self-checking bench for updown_counter
module tb_updown_counter;

  localparam int TICK_DIV  = 4;
  localparam int MAX_COUNT = 9999;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_run_stop = 1'b0;
  logic        btn_clear = 1'b0;
  logic        btn_mode = 1'b0;
  logic [13:0] count_data;
  logic        run_led;
  logic        mode_led;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  updown_counter #(
    .TICK_DIV (TICK_DIV),
    .MAX_COUNT(MAX_COUNT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_run_stop(btn_run_stop),
    .btn_clear   (btn_clear),
    .btn_mode    (btn_mode),
    .count_data  (count_data),
    .run_led     (run_led),
    .mode_led    (mode_led)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds the given buttons high for exactly one rising edge.
  task automatic press(input logic rs, input logic clr, input logic md);
    btn_run_stop = rs;
    btn_clear    = clr;
    btn_mode     = md;
    @(negedge clk);
    btn_run_stop = 1'b0;
    btn_clear    = 1'b0;
    btn_mode     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    reset = 1'b1;
    press(1'b1, 1'b1, 1'b1);
    cycles(1);
    check("rst_count", int'(count_data), 0);
    check("rst_run_led", int'(run_led), 0);
    check("rst_mode_led", int'(mode_led), 0);
    reset = 1'b0;

    // Run from 0: first step 4 cycles after RUN entry, 10 after 40 cycles.
    press(1'b1, 1'b0, 1'b0);
    check("run_entry_led", int'(run_led), 1);
    check("run_entry_count", int'(count_data), 0);
    cycles(3);
    check("first_step_not_early", int'(count_data), 0);
    cycles(1);
    check("first_step", int'(count_data), 1);
    cycles(35);
    check("count_at_39", int'(count_data), 9);
    cycles(1);
    check("count_at_40", int'(count_data), 10);
    check("run_led_at_40", int'(run_led), 1);
    cycles(452);
    check("count_at_123", int'(count_data), 123);

    // Reset mid-run overrides simultaneous buttons.
    reset = 1'b1;
    btn_mode = 1'b1;
    btn_run_stop = 1'b1;
    @(negedge clk);
    check("midrun_rst_count", int'(count_data), 0);
    check("midrun_rst_run_led", int'(run_led), 0);
    check("midrun_rst_mode_led", int'(mode_led), 0);
    reset = 1'b0;
    btn_mode = 1'b0;
    btn_run_stop = 1'b0;
    cycles(6);
    check("post_rst_idle_count", int'(count_data), 0);
    check("post_rst_idle_run", int'(run_led), 0);

    // Clear and run_stop together at 57; run_stop in CLEAR ignored, mode honoured.
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    cycles(228);
    check("count_at_57", int'(count_data), 57);
    press(1'b1, 1'b1, 1'b0);
    check("clear_count", int'(count_data), 0);
    check("clear_run_led", int'(run_led), 0);
    press(1'b1, 1'b0, 1'b1);
    check("after_clear_run_led", int'(run_led), 0);
    check("after_clear_mode_led", int'(mode_led), 1);
    check("after_clear_count", int'(count_data), 0);
    cycles(8);
    check("stopped_after_clear_count", int'(count_data), 0);
    check("stopped_after_clear_run", int'(run_led), 0);

    // Down wrap from 0, mode change on a tick edge, up wrap at MAX, stop on a tick.
    do_reset();
    check("mode_after_reset", int'(mode_led), 0);
    press(1'b0, 1'b0, 1'b1);
    check("mode_toggled", int'(mode_led), 1);
    press(1'b1, 1'b0, 1'b0);
    cycles(4);
    check("down_wrap", int'(count_data), 9999);
    check("down_wrap_mode", int'(mode_led), 1);
    cycles(3);
    press(1'b0, 1'b0, 1'b1);
    check("mode_on_tick_old_dir", int'(count_data), 9998);
    check("mode_on_tick_new_led", int'(mode_led), 0);
    cycles(4);
    check("up_to_max", int'(count_data), 9999);
    cycles(4);
    check("up_wrap", int'(count_data), 0);
    cycles(3);
    press(1'b1, 1'b0, 1'b0);
    check("stop_on_tick_count", int'(count_data), 1);
    check("stop_on_tick_run_led", int'(run_led), 0);
    cycles(8);
    check("stop_on_tick_hold", int'(count_data), 1);

    // Stop at 5, idle 100 cycles, restart: next step a full period later.
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    cycles(20);
    check("count_at_5", int'(count_data), 5);
    cycles(1);
    press(1'b1, 1'b0, 1'b0);
    check("stop_at_5_count", int'(count_data), 5);
    check("stop_at_5_run_led", int'(run_led), 0);
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      check("idle_hold", int'(count_data), 5);
    end
    press(1'b1, 1'b0, 1'b0);
    check("restart_run_led", int'(run_led), 1);
    cycles(3);
    check("restart_not_early", int'(count_data), 5);
    cycles(1);
    check("restart_step", int'(count_data), 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
